ysyx_22040759_hazard_ctrl: RTL and testbench
============================================

// Module: ysyx_22040759_hazard_ctrl
// PURPOSE
//  Parametrised hazard controller for the 5-stage RV64 pipeline. Replaces the single-cycle load-use detector.
//  Adds:
//   - multi-cycle load-use stall, sized to memory latency
//   - scoreboard for outstanding multi-cycle MUL/DIV results
//   - branch/jump flush
//   - EX-stage forwarding selects
//  Sits beside the ID/EX pipeline registers; drives PC/IF_ID enables, ID/EX bubble and forwarding muxes.
// PARAMETERS
//  REG_AW    5   register index width; NREG = 2**REG_AW scoreboard bits
//  LOAD_LAT  1   load-use stall cycles per hazard (>=1)
//  MDU_DEPTH 2   max outstanding MUL/DIV ops (>=1)
//  CNT_W     3   width of LOAD_LAT counter and MDU outstanding counter; must hold max(LOAD_LAT, MDU_DEPTH)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        reset, synchronous, active-high
//  id_rs1/id_rs2  in   REG_AW   source regs of instruction in ID
//  id_rs1_used    in   1        ID instruction reads rs1
//  id_rs2_used    in   1        ID instruction reads rs2
//  id_is_mdu      in   1        ID instruction is MUL/DIV
//  ex_rd          in   REG_AW   dest of instruction in EX
//  ex_memread     in   1        EX instruction is a load
//  ex_rs1/ex_rs2  in   REG_AW   sources of instruction in EX (forwarding)
//  ex_redirect    in   1        EX resolved taken branch/jump
//  mdu_issue      in   1        MUL/DIV accepted by MDU this cycle
//  mdu_rd         in   REG_AW   dest of issued MUL/DIV
//  mdu_done       in   1        MDU writes back this cycle
//  mdu_done_rd    in   REG_AW   dest of completing op
//  mem_rd         in   REG_AW   EX/MEM dest
//  mem_regwrite   in   1        EX/MEM writes a register
//  wb_rd          in   REG_AW   MEM/WB dest
//  wb_regwrite    in   1        MEM/WB writes a register
//  pc_stall       out  1        hold PC
//  ifid_stall     out  1        hold IF/ID
//  idex_bubble    out  1        insert NOP into ID/EX
//  ifid_flush     out  1        clear IF/ID
//  fwd_a/fwd_b    out  2        00 regfile, 01 EX/MEM, 10 MEM/WB
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, scoreboard cleared, counters 0.
//  - Index 0 never causes a hazard, never forwards, is never set in the scoreboard.
//  - FSM states: IDLE, LU_STALL.
//    - IDLE -> LU_STALL when lu_hit: ex_memread & ex_rd!=0 & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)).
//    - The detect cycle is stall cycle 1. cnt loads LOAD_LAT-1.
//    - LU_STALL decrements cnt each cycle; returns to IDLE when cnt==0.
//    - Total stall is exactly LOAD_LAT cycles. LOAD_LAT=1 never enters LU_STALL (combinational stall only).
//  - Scoreboard:
//    - mdu_issue sets sb[mdu_rd]; mdu_done clears sb[mdu_done_rd].
//    - Same reg set and cleared in one cycle: set wins.
//    - outstanding count +1 on issue, -1 on done, unchanged when both occur.
//  - mdu_hit: (id_rs1_used & sb[id_rs1]) | (id_rs2_used & sb[id_rs2]) | (id_is_mdu & outstanding==MDU_DEPTH).
//  - stall = lu_hit | state==LU_STALL | mdu_hit. pc_stall = ifid_stall = idex_bubble = stall, combinational same cycle.
//  - Flush: ex_redirect has priority over stall.
//    - Outputs: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0.
//    - FSM forced to IDLE next cycle, cnt cleared.
//    - Scoreboard untouched; issued MDU ops still complete.
//  - Forwarding (fwd_a uses ex_rs1, fwd_b uses ex_rs2):
//    - 01 if mem_regwrite & mem_rd!=0 & mem_rd==src.
//    - Else 10 if wb_regwrite & wb_rd!=0 & wb_rd==src.
//    - Else 00. EX/MEM has priority.
//  - mdu_done with outstanding==0 is ignored (count saturates at 0). mdu_issue at full is a caller error; count saturates at MDU_DEPTH.
//  - rst asserted mid-stall: next cycle all state is reset, no residual stall.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: adds outputs perf_lu_cyc, perf_mdu_cyc, perf_flush (32-bit each).
//    - Cycle counts of LU stall, MDU stall and flush events; zeroed by rst; wrap at 2**32.
//  - Not defined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. LOAD_LAT=3; ex_memread=1, ex_rd=5, id_rs1=5, id_rs1_used=1
//     -> pc_stall/ifid_stall/idex_bubble=1 for exactly 3 cycles, then 0.
//  2. ex_rd=0 load with id_rs1=0 -> no stall.
//     Same load with id_rs1_used=0 and id_rs1=5 -> no stall.
//  3. mdu_issue rd=7; next ID reads x7 -> stall until cycle of mdu_done rd=7, released next cycle.
//     Issue rd=7 and done rd=7 in same cycle -> sb[7] stays 1.
//  4. MDU_DEPTH=2, two issues outstanding, id_is_mdu=1 -> stall; one mdu_done -> stall drops next cycle.
//  5. In LU_STALL (cnt=1) ex_redirect=1 -> ifid_flush=1, idex_bubble=1, pc_stall=0; next cycle state IDLE, no stall.
//  6. mem_rd=wb_rd=9, both regwrite, ex_rs1=9 -> fwd_a=01.
//     mem_regwrite=0 -> fwd_a=10.
//     ex_rs2=0 with wb_rd=0 -> fwd_b=00.

Source files
------------

// File: rtl/ysyx_22040759_hazard_ctrl.sv
// ysyx_22040759_hazard_ctrl
//  Hazard controller for the 5-stage RV64 pipeline. It handles:
//  - multi-cycle load-use stalls,
//  - a scoreboard of outstanding multi-cycle MUL/DIV results,
//  - branch/jump flushes,
//  - EX-stage forwarding selects.
//
//  Inputs:
//    clk, rst (synchronous, active-high)
//    id_rs1/id_rs2/id_rs*_used/id_is_mdu   ID-stage sources
//    ex_rd/ex_memread/ex_rs1/ex_rs2        EX-stage instruction
//    ex_redirect                           taken branch/jump resolved in EX
//    mdu_issue/mdu_rd/mdu_done/mdu_done_rd MUL/DIV issue and writeback
//    mem_rd/mem_regwrite, wb_rd/wb_regwrite  forwarding sources
//
//  Outputs:
//    pc_stall, ifid_stall, idex_bubble, ifid_flush
//    fwd_a/fwd_b: 00 regfile, 01 EX/MEM, 10 MEM/WB
//
//  Optional macro HAZARD_PERF_EN adds three 32-bit counters:
//    perf_lu_cyc   load-use stall cycles
//    perf_mdu_cyc  MDU stall cycles
//    perf_flush    flush events
module ysyx_22040759_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int MDU_DEPTH = 2,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_mdu,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_redirect,
  input  logic              mdu_issue,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic              mdu_done,
  input  logic [REG_AW-1:0] mdu_done_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_lu_cyc,
  output logic [31:0]       perf_mdu_cyc,
  output logic [31:0]       perf_flush,
`endif
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int NREG = 2**REG_AW;

  typedef enum logic {IDLE, LU_STALL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] outstanding;
  logic [NREG-1:0]  sb;
  logic [NREG-1:0]  sb_nxt;
  logic             lu_hit, lu_stall, mdu_full, mdu_hit, stall;

  assign lu_hit = ex_memread && (ex_rd != '0) &&
                  ((id_rs1_used && ex_rd == id_rs1) ||
                   (id_rs2_used && ex_rd == id_rs2));

  // The detect cycle is the first stall cycle.
  // LU_STALL covers the remaining LOAD_LAT-1 stall cycles.
  assign lu_stall = lu_hit || (state == LU_STALL);

  assign mdu_full = (outstanding == CNT_W'(MDU_DEPTH));

  // sb[0] is held at zero, so x0 never raises an MDU hazard.
  assign mdu_hit = (id_rs1_used && sb[id_rs1]) ||
                   (id_rs2_used && sb[id_rs2]) ||
                   (id_is_mdu && mdu_full);

  assign stall = lu_stall || mdu_hit;

  // A redirect overrides a stall.
  // The wrong-path instruction in ID is dropped, not held.
  assign pc_stall    = !rst && stall && !ex_redirect;
  assign ifid_stall  = !rst && stall && !ex_redirect;
  assign idex_bubble = !rst && (stall || ex_redirect);
  assign ifid_flush  = !rst && ex_redirect;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (mem_regwrite && mem_rd != '0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != '0 && wb_rd == src)    return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a = rst ? 2'b00 : fwd_sel(ex_rs1);
  assign fwd_b = rst ? 2'b00 : fwd_sel(ex_rs2);

  // Load-use FSM
  always_ff @(posedge clk) begin
    if (rst || ex_redirect) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lu_hit && LOAD_LAT > 1) begin
            state <= LU_STALL;
            cnt   <= CNT_W'(LOAD_LAT - 1);
          end
        end
        LU_STALL: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Scoreboard.
  // The set is applied last, so a same-cycle issue and completion to the
  // same register leaves the bit set.
  always_comb begin
    sb_nxt = sb;
    if (mdu_done) sb_nxt[mdu_done_rd] = 1'b0;
    if (mdu_issue) sb_nxt[mdu_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb          <= '0;
      outstanding <= '0;
    end else begin
      sb <= sb_nxt;
      // The count saturates at both ends.
      // An issue and a done in the same cycle cancel out.
      case ({mdu_issue, mdu_done})
        2'b10: if (!mdu_full) outstanding <= outstanding + 1'b1;
        2'b01: if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_cyc  <= '0;
      perf_mdu_cyc <= '0;
      perf_flush   <= '0;
    end else begin
      if (lu_stall && !ex_redirect) perf_lu_cyc  <= perf_lu_cyc + 32'd1;
      if (mdu_hit && !ex_redirect)  perf_mdu_cyc <= perf_mdu_cyc + 32'd1;
      if (ex_redirect)              perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040759_hazard_ctrl.sv
// Self-checking bench for ysyx_22040759_hazard_ctrl (LOAD_LAT=3, MDU_DEPTH=2).
// Each step drives one cycle of inputs and pushes the expected output vector
// {pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b}.
// The expected vector is popped and compared 1 ns after the falling edge.
module tb_ysyx_22040759_hazard_ctrl;

  localparam logic [7:0] NONE  = 8'b1110_0000 & 8'h00;
  localparam logic [7:0] STALL = 8'b1110_0000;
  localparam logic [7:0] FLUSH = 8'b0011_0000;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       u1;
    logic       u2;
    logic       is_mdu;
    logic [4:0] ex_rd;
    logic       memread;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       redirect;
    logic       issue;
    logic [4:0] mrd;
    logic       done;
    logic [4:0] drd;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic [7:0] want;
  } stim_t;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mdu_rd, mdu_done_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, id_is_mdu, ex_memread, ex_redirect;
  logic       mdu_issue, mdu_done, mem_regwrite, wb_regwrite;
  logic       pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cyc, perf_mdu_cyc, perf_flush;
`endif

  logic [7:0] obs;
  logic [7:0] exp_q[$];
  int         nchk, nfail;

  assign obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b};

  ysyx_22040759_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(3), .MDU_DEPTH(2), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_is_mdu(id_is_mdu),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_redirect(ex_redirect),
    .mdu_issue(mdu_issue), .mdu_rd(mdu_rd),
    .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
`ifdef HAZARD_PERF_EN
    .perf_lu_cyc(perf_lu_cyc), .perf_mdu_cyc(perf_mdu_cyc), .perf_flush(perf_flush),
`endif
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input stim_t s);
    rst          = s.rst;
    id_rs1       = s.id_rs1;
    id_rs2       = s.id_rs2;
    id_rs1_used  = s.u1;
    id_rs2_used  = s.u2;
    id_is_mdu    = s.is_mdu;
    ex_rd        = s.ex_rd;
    ex_memread   = s.memread;
    ex_rs1       = s.ex_rs1;
    ex_rs2       = s.ex_rs2;
    ex_redirect  = s.redirect;
    mdu_issue    = s.issue;
    mdu_rd       = s.mrd;
    mdu_done     = s.done;
    mdu_done_rd  = s.drd;
    mem_rd       = s.mem_rd;
    mem_regwrite = s.mem_rw;
    wb_rd        = s.wb_rd;
    wb_regwrite  = s.wb_rw;
  endtask

  task automatic test_reset();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{rst:1, memread:1, ex_rd:5, id_rs1:5, u1:1, want:NONE, default:0});
    s.push_back('{rst:1, redirect:1, mem_rd:3, mem_rw:1, ex_rs1:3, want:NONE, default:0});
    s.push_back('{want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL reset step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:NONE, default:0});
    s.push_back('{memread:1, ex_rd:6, id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL load_use step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_no_hazard();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{memread:1, ex_rd:0, id_rs1:0, u1:1, want:NONE, default:0});
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:0, want:NONE, default:0});
    s.push_back('{memread:1, ex_rd:5, id_rs2:5, u2:0, id_rs1:6, u1:1, want:NONE, default:0});
    s.push_back('{want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL no_hazard step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_mdu_scoreboard();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{issue:1, mrd:7, want:NONE, default:0});
    s.push_back('{id_rs1:7, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:7, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:7, u1:1, done:1, drd:7, want:STALL, default:0});
    s.push_back('{id_rs1:7, u1:1, want:NONE, default:0});
    // A same-cycle issue and done on x7 keeps sb[7] set.
    s.push_back('{issue:1, mrd:7, want:NONE, default:0});
    s.push_back('{issue:1, mrd:7, done:1, drd:7, id_rs2:7, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:7, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:7, u2:1, done:1, drd:7, want:STALL, default:0});
    s.push_back('{id_rs2:7, u2:1, want:NONE, default:0});
    // x0 is never marked busy.
    s.push_back('{issue:1, mrd:0, want:NONE, default:0});
    s.push_back('{id_rs1:0, u1:1, want:NONE, default:0});
    s.push_back('{done:1, drd:0, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL mdu_scoreboard step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_mdu_depth();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{done:1, drd:3, want:NONE, default:0});
    s.push_back('{issue:1, mrd:10, want:NONE, default:0});
    s.push_back('{issue:1, mrd:11, want:NONE, default:0});
    s.push_back('{is_mdu:1, want:STALL, default:0});
    s.push_back('{is_mdu:1, done:1, drd:10, want:STALL, default:0});
    s.push_back('{is_mdu:1, want:NONE, default:0});
    s.push_back('{done:1, drd:11, want:NONE, default:0});
    s.push_back('{is_mdu:1, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL mdu_depth step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, redirect:1, want:FLUSH, default:0});
    s.push_back('{id_rs1:5, u1:1, want:NONE, default:0});
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:1, redirect:1, want:FLUSH, default:0});
    s.push_back('{id_rs1:5, u1:1, want:NONE, default:0});
    // A flush leaves the scoreboard intact.
    s.push_back('{issue:1, mrd:8, want:NONE, default:0});
    s.push_back('{id_rs1:8, u1:1, redirect:1, want:FLUSH, default:0});
    s.push_back('{id_rs1:8, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:8, u1:1, done:1, drd:8, want:STALL, default:0});
    s.push_back('{id_rs1:8, u1:1, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL flush step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_forwarding();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{mem_rd:9, mem_rw:1, wb_rd:9, wb_rw:1, ex_rs1:9, want:8'b0000_0100, default:0});
    s.push_back('{mem_rd:9, mem_rw:0, wb_rd:9, wb_rw:1, ex_rs1:9, want:8'b0000_1000, default:0});
    s.push_back('{wb_rd:0, wb_rw:1, ex_rs2:0, want:NONE, default:0});
    s.push_back('{mem_rd:0, mem_rw:1, ex_rs1:0, ex_rs2:0, want:NONE, default:0});
    s.push_back('{mem_rd:4, mem_rw:1, wb_rd:3, wb_rw:1, ex_rs1:3, ex_rs2:4, want:8'b0000_1001, default:0});
    s.push_back('{mem_rd:4, mem_rw:1, wb_rd:3, wb_rw:1, ex_rs1:5, ex_rs2:6, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL forwarding step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{rst:1, id_rs1:5, u1:1, want:NONE, default:0});
    s.push_back('{id_rs1:5, u1:1, want:NONE, default:0});
    s.push_back('{issue:1, mrd:14, want:NONE, default:0});
    s.push_back('{rst:1, want:NONE, default:0});
    s.push_back('{id_rs1:14, u1:1, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL reset_mid_stall step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [7:0] e;
    s.push_back('{memread:1, ex_rd:5, id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{id_rs1:5, u1:1, want:STALL, default:0});
    s.push_back('{memread:1, ex_rd:6, id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:STALL, default:0});
    s.push_back('{id_rs2:6, u2:1, want:NONE, default:0});
    foreach (s[i]) begin
      @(negedge clk); drive(s[i]); exp_q.push_back(s[i].want);
      #1; e = exp_q.pop_front(); nchk++;
      if (obs !== e) begin nfail++; $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  initial begin
    stim_t z;
    nchk  = 0;
    nfail = 0;
    z = '0;
    drive(z);
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu_scoreboard();
    test_mdu_depth();
    test_flush();
    test_forwarding();
    test_reset_mid_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
